// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// RD_LAT-deep delay line for read valid/data/err; flushed by rst.
// Data in each stage holds when its valid is low, so the output keeps the last read word.
module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_err,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_err
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];

    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = in_vld;
        err_d[0] = in_vld & in_err;
        dat_d[0] = in_vld ? in_dat : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_err = err_q[RD_LAT-1];
    assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with byte-lane writes, post-reset clear sweep and selectable read-during-write.
// Read data appears RD_LAT edges after the request edge; no backpressure, requests are dropped while init_busy.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  init_busy
);

    localparam int NL = lanes(DATA_W);
    localparam logic [ADDR_W:0] LAST_L = (ADDR_W+1)'(DEPTH - 1);

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("RD_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must be in 1..2**ADDR_W");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    ram_state_e        state_q, state_d;
    logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
    logic              ready, wr_in_rng, rd_in_rng, wr_acc, rd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [DATA_W-1:0] mem_wdat, wr_old, wr_merge, rd_word;
    logic              cap_vld_q, cap_vld_d, cap_err_q, cap_err_d;
    logic [DATA_W-1:0] cap_dat_q, cap_dat_d;

    // A full-size array has no out-of-range addresses, so skip the compare entirely.
    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign wr_in_rng = 1'b1;
        assign rd_in_rng = 1'b1;
    end else begin : g_part
        localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
        assign wr_in_rng = ({1'b0, wr_addr} < DEPTH_L);
        assign rd_in_rng = ({1'b0, rd_addr} < DEPTH_L);
    end

    assign ready     = (state_q == ST_READY);
    assign init_busy = ~ready;
    assign wr_acc    = wr_en & wr_in_rng & ready & ~rst;
    assign rd_acc    = rd_en & ready & ~rst;

    always_comb begin
        wr_old   = mem_q[wr_addr];
        wr_merge = wr_old;
        for (int i = 0; i < NL; i++) begin
            if (wr_be[i]) begin
                wr_merge[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = wr_acc;
        mem_idx   = wr_addr;
        mem_wdat  = wr_merge;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = ~rst;
                mem_idx   = clr_ptr_q[ADDR_W-1:0];
                mem_wdat  = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_L) begin
                    state_d = ST_READY;
                end
            end
            default: begin
            end
        endcase
    end

    // The array read is captured on the request edge so RDW_OLD sees the pre-write word.
    always_comb begin
        rd_word = mem_q[rd_addr];
        if (RDW_MODE == RDW_NEW && wr_acc && wr_addr == rd_addr) begin
            rd_word = wr_merge;
        end
        cap_vld_d = rd_acc;
        cap_err_d = rd_acc & ~rd_in_rng;
        cap_dat_d = cap_dat_q;
        if (rd_acc) begin
            cap_dat_d = rd_in_rng ? rd_word : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            clr_ptr_q <= '0;
            cap_vld_q <= 1'b0;
            cap_err_q <= 1'b0;
            cap_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            cap_vld_q <= cap_vld_d;
            cap_err_q <= cap_err_d;
            cap_dat_q <= cap_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdat;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (cap_vld_q),
        .in_dat  (cap_dat_q),
        .in_err  (cap_err_q),
        .out_vld (rd_valid),
        .out_dat (rd_data),
        .out_err (rd_err)
    );

endmodule
